// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg: shared definitions for the registered control sequencer.
// Holds ALU operation codes, write-back source encodings, opcode prefix
// constants, register index constants, the sequencer state enum and the
// fixed-width part of the registered control bundle.
package ctrl_seq_pkg;

  // ALU operations
  localparam logic [2:0] kADD = 3'd0;
  localparam logic [2:0] kSUB = 3'd1;
  localparam logic [2:0] kLSH = 3'd2;
  localparam logic [2:0] kRSH = 3'd3;
  localparam logic [2:0] kXOR = 3'd4;
  localparam logic [2:0] kORR = 3'd5;
  localparam logic [2:0] kRXR = 3'd6;

  // Write-back source select
  localparam logic [2:0] kWS_ALU  = 3'b000;
  localparam logic [2:0] kWS_MEM  = 3'b001;
  localparam logic [2:0] kWS_LLUT = 3'b010;
  localparam logic [2:0] kWS_MLUT = 3'b011;
  localparam logic [2:0] kWS_IMM  = 3'b100;

  // Opcode prefixes, compared against the top bits of the instruction
  localparam logic [2:0] kOP_LSL    = 3'b000;
  localparam logic [2:0] kOP_LSR    = 3'b001;
  localparam logic [4:0] kOP_LD     = 5'b01000;
  localparam logic [4:0] kOP_ST     = 5'b01001;
  localparam logic [3:0] kOP_XOR    = 4'b0110;
  localparam logic [3:0] kOP_RXR    = 4'b0111;
  localparam logic [3:0] kOP_JMP    = 4'b1000;
  localparam logic [3:0] kOP_SPC    = 4'b1001;
  localparam logic [3:0] kOP_LUT    = 4'b1010;
  localparam logic [5:0] kOP_CTC    = 6'b101100;
  localparam logic [3:0] kOP_CPY    = 4'b1100;
  localparam logic [3:0] kOP_OR     = 4'b1101;
  localparam logic [3:0] kOP_ADDSUB = 4'b1110;
  localparam logic [3:0] kOP_MOV    = 4'b1111;
  localparam logic [8:0] kOP_ACK    = 9'h1FF;

  // Register indices
  localparam int unsigned kR0 = 0;
  localparam int unsigned kR1 = 1;
  localparam int unsigned kR8 = 8;
  localparam int unsigned kR9 = 9;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } state_e;

  // Fixed-width fields of the registered bundle
  typedef struct packed {
    logic       ov;
    logic       ack;
    logic       je;
    logic       jne;
    logic       offs;
    logic       rwe;
    logic       mwe;
    logic [1:0] pcs;
    logic [2:0] ws;
    logic [2:0] alu;
  } ctrl_flags_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational 9-bit instruction to control-bundle decoder.
// Ports:
//   inst_i                 instruction word
//   je_o/jne_o/offs_o      branch controls
//   rwe_o/mwe_o            register / memory write enables
//   pcs_o, ws_o, alu_o     PC register select, write-back source, ALU op
//   ra_o/rb_o/wa_o         register addresses (RW bits)
//   imm_o                  zero-extended inst_i[4:0]
//   is_ack_o, is_ld_o      instruction class flags for the sequencer
module ctrl_decode
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned RW = 4,
  parameter int unsigned DW = 8
) (
  input  logic [8:0]    inst_i,
  output logic          je_o,
  output logic          jne_o,
  output logic          offs_o,
  output logic          rwe_o,
  output logic          mwe_o,
  output logic [1:0]    pcs_o,
  output logic [2:0]    ws_o,
  output logic [2:0]    alu_o,
  output logic [RW-1:0] ra_o,
  output logic [RW-1:0] rb_o,
  output logic [RW-1:0] wa_o,
  output logic [DW-1:0] imm_o,
  output logic          is_ack_o,
  output logic          is_ld_o
);

  logic [RW-1:0] x;

  always_comb begin
    je_o     = 1'b0;
    jne_o    = 1'b0;
    offs_o   = 1'b0;
    rwe_o    = 1'b0;
    mwe_o    = 1'b0;
    pcs_o    = '0;
    ws_o     = kWS_ALU;
    alu_o    = kADD;
    ra_o     = '0;
    rb_o     = '0;
    wa_o     = '0;
    imm_o    = DW'(inst_i[4:0]);
    is_ack_o = 1'b0;
    is_ld_o  = 1'b0;
    x        = RW'(inst_i[4:2]);

    // Ack shares the mov prefix, so it must be tested first
    if (inst_i == kOP_ACK) begin
      is_ack_o = 1'b1;
    end else if (inst_i[8:6] == kOP_LSL || inst_i[8:6] == kOP_LSR) begin
      rwe_o = 1'b1;
      wa_o  = RW'(inst_i[5:3]);
      ra_o  = RW'(kR8);
      rb_o  = RW'(inst_i[2:0]);
      alu_o = (inst_i[8:6] == kOP_LSR) ? kRSH : kLSH;
    end else if (inst_i[8:4] == kOP_LD) begin
      is_ld_o = 1'b1;
      rwe_o   = 1'b1;
      wa_o    = RW'(inst_i[3:1]);
      ra_o    = RW'(kR1);
      ws_o    = kWS_MEM;
    end else if (inst_i[8:4] == kOP_ST) begin
      mwe_o = 1'b1;
      ra_o  = RW'(kR1);
      rb_o  = RW'(inst_i[3:1]);
    end else if (inst_i[8:5] == kOP_XOR) begin
      rwe_o = 1'b1;
      wa_o  = x;
      ra_o  = x;
      rb_o  = RW'(kR8);
      alu_o = kXOR;
    end else if (inst_i[8:5] == kOP_RXR) begin
      rwe_o = 1'b1;
      wa_o  = x;
      ra_o  = x;
      alu_o = kRXR;
    end else if (inst_i[8:5] == kOP_JMP) begin
      jne_o = inst_i[4];
      je_o  = ~inst_i[4];
      pcs_o = inst_i[3:2];
    end else if (inst_i[8:5] == kOP_SPC) begin
      pcs_o  = inst_i[4:3];
      offs_o = inst_i[2];
    end else if (inst_i[8:5] == kOP_LUT) begin
      rwe_o = 1'b1;
      wa_o  = RW'(kR8);
      if (inst_i[1]) begin
        ws_o = kWS_MLUT;
        rb_o = x;
      end else begin
        ws_o = kWS_LLUT;
        ra_o = x;
      end
    end else if (inst_i[8:3] == kOP_CTC) begin
      rwe_o = 1'b1;
      wa_o  = RW'(kR9);
      ra_o  = RW'(kR0);
      rb_o  = RW'(kR0);
      alu_o = kADD;
    end else if (inst_i[8:5] == kOP_CPY) begin
      rwe_o = 1'b1;
      wa_o  = x;
      ra_o  = RW'(kR8);
      rb_o  = RW'(kR0);
      alu_o = kADD;
    end else if (inst_i[8:5] == kOP_OR) begin
      rwe_o = 1'b1;
      wa_o  = x;
      ra_o  = x;
      rb_o  = RW'({1'b1, inst_i[1:0]});
      alu_o = kORR;
    end else if (inst_i[8:5] == kOP_ADDSUB) begin
      rwe_o = 1'b1;
      wa_o  = x;
      ra_o  = x;
      rb_o  = RW'(kR8);
      alu_o = inst_i[1] ? kSUB : kADD;
    end else if (inst_i[8:5] == kOP_MOV) begin
      rwe_o = 1'b1;
      wa_o  = RW'(kR8);
      ws_o  = kWS_IMM;
    end
  end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: registered control decoder with load wait-state sequencer,
// sticky halt/Ack and a saturating retired-instruction counter.
// Ports:
//   Clk, Reset (sync, active-high)
//   Instruction, InstValid       fetch side
//   Stall                        PC hold request
//   OutValid + control bundle    registered decode result
//   Ack                          sticky program-done flag
//   InstCount                    saturating retired-instruction count
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int unsigned RW      = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [8:0]       Instruction,
  input  logic             InstValid,
  output logic             Stall,
  output logic             OutValid,
  output logic             JumpEqual,
  output logic             JumpNotEqual,
  output logic             OffsetEn,
  output logic             RegWrEn,
  output logic             MemWrEn,
  output logic             Ack,
  output logic [1:0]       PCRegSelect,
  output logic [2:0]       WriteSource,
  output logic [2:0]       ALUOp,
  output logic [RW-1:0]    ReadRegAddrA,
  output logic [RW-1:0]    ReadRegAddrB,
  output logic [RW-1:0]    WriteRegAddr,
  output logic [DW-1:0]    ImmOut,
  output logic [CNT_W-1:0] InstCount
);

  logic          dec_je, dec_jne, dec_offs, dec_rwe, dec_mwe;
  logic          dec_ack, dec_ld;
  logic [1:0]    dec_pcs;
  logic [2:0]    dec_ws, dec_alu;
  logic [RW-1:0] dec_ra, dec_rb, dec_wa;
  logic [DW-1:0] dec_imm;

  ctrl_decode #(
    .RW(RW),
    .DW(DW)
  ) u_decode (
    .inst_i  (Instruction),
    .je_o    (dec_je),
    .jne_o   (dec_jne),
    .offs_o  (dec_offs),
    .rwe_o   (dec_rwe),
    .mwe_o   (dec_mwe),
    .pcs_o   (dec_pcs),
    .ws_o    (dec_ws),
    .alu_o   (dec_alu),
    .ra_o    (dec_ra),
    .rb_o    (dec_rb),
    .wa_o    (dec_wa),
    .imm_o   (dec_imm),
    .is_ack_o(dec_ack),
    .is_ld_o (dec_ld)
  );

  state_e            state_q, state_d;
  logic [1:0]        wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  ctrl_flags_t       flags_q, flags_d;
  logic [RW-1:0]     ra_q, ra_d, rb_q, rb_d, wa_q, wa_d;
  logic [DW-1:0]     imm_q, imm_d;
  logic              retire;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      count_q <= '0;
      flags_q <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      wa_q    <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      count_q <= count_d;
      flags_q <= flags_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      wa_q    <= wa_d;
      imm_q   <= imm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    count_d = count_q;
    flags_d = flags_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    wa_d    = wa_q;
    imm_d   = imm_q;
    retire  = 1'b0;

    unique case (state_q)
      RUN: begin
        flags_d = '0;
        ra_d    = '0;
        rb_d    = '0;
        wa_d    = '0;
        imm_d   = '0;
        if (InstValid) begin
          if (dec_ack) begin
            flags_d.ack = 1'b1;
            state_d     = HALT;
            retire      = 1'b1;
          end else begin
            flags_d.ov   = 1'b1;
            flags_d.je   = dec_je;
            flags_d.jne  = dec_jne;
            flags_d.offs = dec_offs;
            flags_d.rwe  = dec_rwe;
            flags_d.mwe  = dec_mwe;
            flags_d.pcs  = dec_pcs;
            flags_d.ws   = dec_ws;
            flags_d.alu  = dec_alu;
            ra_d         = dec_ra;
            rb_d         = dec_rb;
            wa_d         = dec_wa;
            imm_d        = dec_imm;
            retire       = 1'b1;
            if (dec_ld && MEM_LAT != 0) begin
              // Write-back and retirement move to the last stalled cycle
              state_d     = WAIT;
              wcnt_d      = 2'(MEM_LAT - 1);
              flags_d.rwe = (MEM_LAT == 1);
              retire      = (MEM_LAT == 1);
            end
          end
        end
      end
      WAIT: begin
        if (wcnt_q == 2'd0) begin
          state_d = RUN;
          flags_d = '0;
          ra_d    = '0;
          rb_d    = '0;
          wa_d    = '0;
          imm_d   = '0;
        end else begin
          wcnt_d = wcnt_q - 2'd1;
          if (wcnt_q == 2'd1) begin
            flags_d.rwe = 1'b1;
            retire      = 1'b1;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (retire && count_q != '1) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  assign Stall        = (state_q != RUN);
  assign OutValid     = flags_q.ov;
  assign Ack          = flags_q.ack;
  assign JumpEqual    = flags_q.je;
  assign JumpNotEqual = flags_q.jne;
  assign OffsetEn     = flags_q.offs;
  assign RegWrEn      = flags_q.rwe;
  assign MemWrEn      = flags_q.mwe;
  assign PCRegSelect  = flags_q.pcs;
  assign WriteSource  = flags_q.ws;
  assign ALUOp        = flags_q.alu;
  assign ReadRegAddrA = ra_q;
  assign ReadRegAddrB = rb_q;
  assign WriteRegAddr = wa_q;
  assign ImmOut       = imm_q;
  assign InstCount    = count_q;

endmodule
